// File: rtl/reg_read_port_pkg.sv
// reg_read_port_pkg: shared widths, operand-pair type and FIFO occupancy
// states for the dual-operand register read port.
package reg_read_port_pkg;

    localparam int REG_W = 8;
    localparam int NREGS = 8;
    localparam int SEL_W = 3;

    // One captured operand pair, A in the upper byte.
    typedef struct packed {
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] b;
    } op_pair_t;

    // Occupancy of the operand FIFO.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/reg_read_port_operand_fifo.sv
// operand_fifo: DEPTH-entry synchronous FIFO of operand pairs.
// Ports: clk/rst_n (async active-low), push/push_data (write tail),
// pop (remove head), head (head entry), count (occupancy 0..DEPTH),
// full/empty (decoded from the registered occupancy state).
module operand_fifo
    import reg_read_port_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  op_pair_t               push_data,
    input  logic                   pop,
    output op_pair_t               head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    op_pair_t               mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    occ_state_t             state_r;
    occ_state_t             state_nxt_s;
    logic                   do_push_s;
    logic                   do_pop_s;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push_s = push && (state_r != FULL);
    assign do_pop_s  = pop && (state_r != EMPTY);

    // Next occupancy count and occupancy state.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        state_nxt_s = state_r;
        if (do_push_s && !do_pop_s) begin
            cnt_nxt_s = cnt_r + ONE_C;
        end else if (do_pop_s && !do_push_s) begin
            cnt_nxt_s = cnt_r - ONE_C;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        case (state_r)
            EMPTY: begin
                if (do_push_s) begin
                    state_nxt_s = PARTIAL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            PARTIAL: begin
                if (do_push_s && !do_pop_s && (cnt_r == (DEPTH_C - ONE_C))) begin
                    state_nxt_s = FULL;
                end else if (do_pop_s && !do_push_s && (cnt_r == ONE_C)) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = PARTIAL;
                end
            end
            FULL: begin
                if (do_pop_s) begin
                    state_nxt_s = PARTIAL;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Pointers, count and occupancy state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= EMPTY;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            cnt_r   <= cnt_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    // Entry storage; cleared on reset so no stale operand is ever observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{a: {REG_W{1'b0}}, b: {REG_W{1'b0}}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = cnt_r;
    assign full  = (state_r == FULL);
    assign empty = (state_r == EMPTY);

endmodule

// File: rtl/reg_read_port.sv
// reg_read_port: buffered dual-operand read port for the 8x8 register bank.
// Ports: CLK, RESETn (async active-low); R0..R7 bank contents;
// req_valid/req_ready/req_ra/req_rb request handshake; wr_en/wr_sel/wr_data
// same-cycle bank write for forwarding; out_valid/out_ready/out_a/out_b
// operand output handshake; rd_count completed output transfers mod 256.
module reg_read_port
    import reg_read_port_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [REG_W-1:0] R0,
    input  logic [REG_W-1:0] R1,
    input  logic [REG_W-1:0] R2,
    input  logic [REG_W-1:0] R3,
    input  logic [REG_W-1:0] R4,
    input  logic [REG_W-1:0] R5,
    input  logic [REG_W-1:0] R6,
    input  logic [REG_W-1:0] R7,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_ra,
    input  logic [SEL_W-1:0] req_rb,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [REG_W-1:0] wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] out_a,
    output logic [REG_W-1:0] out_b,
    output logic [7:0]       rd_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [REG_W-1:0] bank_s [NREGS];
    op_pair_t         cap_s;
    op_pair_t         head_s;
    logic [CNT_W-1:0] occ_count_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [7:0]       rd_count_r;

    assign bank_s[0] = R0;
    assign bank_s[1] = R1;
    assign bank_s[2] = R2;
    assign bank_s[3] = R3;
    assign bank_s[4] = R4;
    assign bank_s[5] = R5;
    assign bank_s[6] = R6;
    assign bank_s[7] = R7;

    // Operand select with bypass of a write landing in the same cycle as the read.
    always_comb begin
        cap_s.a = bank_s[req_ra];
        cap_s.b = bank_s[req_rb];
        if (FWD_EN && wr_en && (wr_sel == req_ra)) begin
            cap_s.a = wr_data;
        end else begin
            cap_s.a = bank_s[req_ra];
        end
        if (FWD_EN && wr_en && (wr_sel == req_rb)) begin
            cap_s.b = wr_data;
        end else begin
            cap_s.b = bank_s[req_rb];
        end
    end

    assign push_s = req_valid && !full_s;
    assign pop_s  = out_ready && !empty_s;

    operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESETn),
        .push      (push_s),
        .push_data (cap_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (occ_count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Ready depends only on registered occupancy, so a full FIFO never passes through.
    assign req_ready = (occ_count_s != DEPTH_C);
    assign out_valid = !empty_s;
    assign out_a     = empty_s ? {REG_W{1'b0}} : head_s.a;
    assign out_b     = empty_s ? {REG_W{1'b0}} : head_s.b;

    // Completed output transfers, wrapping 255 -> 0.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rd_count_r <= 8'd0;
        end else if (pop_s) begin
            rd_count_r <= rd_count_r + 8'd1;
        end else begin
            rd_count_r <= rd_count_r;
        end
    end

    assign rd_count = rd_count_r;

endmodule

// File: tb/tb_reg_read_port.sv
// tb_reg_read_port: directed bench for reg_read_port. Two instances share
// stimulus, one with forwarding and one without; a queue-based model is
// checked against both every falling edge, plus literal expectations.
module tb_reg_read_port;

    localparam int DEPTH = 2;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic [7:0] r [8];
    logic       req_valid = 1'b0;
    logic [2:0] req_ra = 3'd0;
    logic [2:0] req_rb = 3'd0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_sel = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       out_ready = 1'b0;

    logic       req_ready1, out_valid1, req_ready0, out_valid0;
    logic [7:0] out_a1, out_b1, rd_count1, out_a0, out_b0, rd_count0;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    reg_read_port #(.DEPTH(DEPTH), .FWD_EN(1'b1)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]),
        .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
        .req_valid(req_valid), .req_ready(req_ready1),
        .req_ra(req_ra), .req_rb(req_rb),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_a(out_a1), .out_b(out_b1), .rd_count(rd_count1)
    );

    reg_read_port #(.DEPTH(DEPTH), .FWD_EN(1'b0)) dut_nf (
        .CLK(CLK), .RESETn(RESETn),
        .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]),
        .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
        .req_valid(req_valid), .req_ready(req_ready0),
        .req_ra(req_ra), .req_rb(req_rb),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_a(out_a0), .out_b(out_b0), .rd_count(rd_count0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: FIFO of {a,b} pairs as queues, one per forwarding setting.
    logic [15:0] q1[$];
    logic [15:0] q0[$];
    logic [7:0]  mrd;
    logic        m_push, m_pop;
    logic [7:0]  fa, fb;

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            q1.delete();
            q0.delete();
            mrd = 8'd0;
        end else begin
            m_push = req_valid && (q1.size() < DEPTH);
            m_pop  = out_ready && (q1.size() > 0);
            fa = (wr_en && wr_sel == req_ra) ? wr_data : r[req_ra];
            fb = (wr_en && wr_sel == req_rb) ? wr_data : r[req_rb];
            if (m_pop) begin
                void'(q1.pop_front());
                void'(q0.pop_front());
                mrd = mrd + 8'd1;
            end
            if (m_push) begin
                q1.push_back({fa, fb});
                q0.push_back({r[req_ra], r[req_rb]});
            end
        end
    end

    logic [15:0] e1, e0;
    always @(negedge CLK) begin
        e1 = (q1.size() > 0) ? q1[0] : 16'h0000;
        e0 = (q0.size() > 0) ? q0[0] : 16'h0000;
        chk("m_req_ready", {31'd0, req_ready1}, {31'd0, q1.size() < DEPTH});
        chk("m_out_valid", {31'd0, out_valid1}, {31'd0, q1.size() > 0});
        chk("m_out_ab", {16'd0, out_a1, out_b1}, {16'd0, e1});
        chk("m_rd_count", {24'd0, rd_count1}, {24'd0, mrd});
        chk("m_nf_req_ready", {31'd0, req_ready0}, {31'd0, q0.size() < DEPTH});
        chk("m_nf_out_valid", {31'd0, out_valid0}, {31'd0, q0.size() > 0});
        chk("m_nf_out_ab", {16'd0, out_a0, out_b0}, {16'd0, e0});
        chk("m_nf_rd_count", {24'd0, rd_count0}, {24'd0, mrd});
    end

    initial begin
        for (int i = 0; i < 8; i++) r[i] = 8'h00;
        repeat (2) @(negedge CLK);
        chk("rst_req_ready", {31'd0, req_ready1}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_rd_count", {24'd0, rd_count1}, 32'd0);
        RESETn = 1'b1;

        // Single read
        r[3] = 8'h5A; r[6] = 8'hC3;
        req_valid = 1'b1; req_ra = 3'd3; req_rb = 3'd6; out_ready = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("single_valid", {31'd0, out_valid1}, 32'd1);
        chk("single_a", {24'd0, out_a1}, 32'h5A);
        chk("single_b", {24'd0, out_b1}, 32'hC3);
        @(negedge CLK);
        chk("single_rd_count", {24'd0, rd_count1}, 32'd1);
        chk("single_empty", {31'd0, out_valid1}, 32'd0);

        // Forwarding
        out_ready = 1'b0;
        r[2] = 8'h11;
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h77;
        req_valid = 1'b1; req_ra = 3'd2; req_rb = 3'd2;
        @(negedge CLK);
        req_valid = 1'b0; wr_en = 1'b0; r[2] = 8'h77;
        chk("fwd_a", {24'd0, out_a1}, 32'h77);
        chk("fwd_b", {24'd0, out_b1}, 32'h77);
        chk("nofwd_a", {24'd0, out_a0}, 32'h11);
        chk("nofwd_b", {24'd0, out_b0}, 32'h11);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("fwd_rd_count", {24'd0, rd_count1}, 32'd2);

        // Fill and backpressure
        r[0] = 8'hA0; r[1] = 8'hA1;
        req_valid = 1'b1; req_ra = 3'd0; req_rb = 3'd1;
        @(negedge CLK);
        r[0] = 8'hB0;
        @(negedge CLK);
        chk("full_ready_low", {31'd0, req_ready1}, 32'd0);
        r[0] = 8'hC0;
        @(negedge CLK);
        chk("full_held", {31'd0, req_ready1}, 32'd0);
        chk("full_head", {24'd0, out_a1}, 32'hA0);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("drain_second", {24'd0, out_a1}, 32'hB0);
        chk("drain_ready", {31'd0, req_ready1}, 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        chk("drain_third", {24'd0, out_a1}, 32'hC0);
        @(negedge CLK);
        out_ready = 1'b0;
        chk("drain_count", {24'd0, rd_count1}, 32'd5);

        // Snapshot, then mid-operation reset with two entries buffered
        r[1] = 8'h10;
        req_valid = 1'b1; req_ra = 3'd1; req_rb = 3'd1;
        @(negedge CLK);
        req_valid = 1'b0; wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h20;
        @(negedge CLK);
        wr_en = 1'b0; r[1] = 8'h20;
        req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("snap_a", {24'd0, out_a1}, 32'h10);
        chk("snap_full", {31'd0, req_ready1}, 32'd0);
        #2 RESETn = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, out_valid1}, 32'd0);
        chk("mrst_a", {24'd0, out_a1}, 32'd0);
        chk("mrst_ready", {31'd0, req_ready1}, 32'd1);
        chk("mrst_rd_count", {24'd0, rd_count1}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        // Stream 257 transfers
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            req_valid = 1'b1;
            req_ra = 3'(i);
            req_rb = 3'(i + 3);
            r[3'(i)] = 8'(i * 7);
            @(negedge CLK);
        end
        req_valid = 1'b0;
        @(negedge CLK);
        chk("wrap_rd_count", {24'd0, rd_count1}, 32'd1);
        chk("wrap_empty", {31'd0, out_valid1}, 32'd0);
        out_ready = 1'b0;
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
